// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: owns the fetch PC, picks the next PC and drives the
// IF/ID register inputs (PC, instr, ExcCode, BDIn) from a synchronous IM.
module if_fetch_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_LO     = 32'h0000_3000,
    parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EN,
    input  logic        Req,
    input  logic        ID_EXLClr,
    input  logic [31:0] EPCOut,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump_d,
    output logic [31:0] i_addr,
    input  logic [31:0] i_rdata,
    output logic [31:0] PC,
    output logic [31:0] instr,
    output logic [4:0]  ExcCode,
    output logic        BDIn
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        bd_reg;
    logic        bd_next;
    logic        first_reg;
    logic        fetch_fault;

    // Exception entry and eret beat a stall; a stalled D re-presents its branch.
    always_comb begin
        pc_next = pc_reg + 32'd4;
        if (Req) begin
            pc_next = EXC_ENTRY;
        end else if (ID_EXLClr) begin
            pc_next = EPCOut;
        end else if (!EN) begin
            pc_next = pc_reg;
        end else if (br_taken) begin
            pc_next = br_target;
        end
    end

    always_comb begin
        bd_next = bd_reg;
        if (Req || ID_EXLClr) begin
            bd_next = 1'b0;
        end else if (EN) begin
            bd_next = jump_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg    <= PC_RESET;
            bd_reg    <= 1'b0;
            first_reg <= 1'b1;
        end else begin
            pc_reg    <= pc_next;
            bd_reg    <= bd_next;
            first_reg <= 1'b0;
        end
    end

    // The IM is still addressed on a bad PC; only its returned data is dropped.
    assign fetch_fault = (pc_reg[1:0] != 2'b00) || (pc_reg < IM_LO) || (pc_reg > IM_HI);

    assign i_addr  = pc_next;
    assign PC      = pc_reg;
    assign ExcCode = fetch_fault ? EXC_ADEL : EXC_NONE;
    assign instr   = (fetch_fault || first_reg) ? 32'h0 : i_rdata;
    assign BDIn    = bd_reg;

endmodule
